// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
// Shared SPI definitions: FSM state type, bus mode and default word width.
// Latency: n/a (declarations and a pure helper function only).
// Backpressure: n/a.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slave_state_t;

    // Mode 0: sclk idles low, data sampled on rising edge, changed on falling edge.
    localparam int SPI_MODE = 0;

    // Word width shared by the spi master and responder.
    localparam int SPI_DATA_W = 8;

    // Saturating 8-bit increment used for the per-frame word counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
`timescale 1ns/1ps
// Multi-flop synchroniser for one asynchronous input with rise/fall pulses.
// Latency: STAGES clk cycles to sync, edge pulse in the cycle sync changes.
// Backpressure: none; pulses are single-cycle and cannot be stalled.
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous input
//   sync       : synchronised level
//   rise, fall : one-cycle pulses on synchronised transitions
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;
    // Fills with ones after reset; edges are only reported once the history
    // flop holds a real sample of din rather than the reset value. This keeps
    // a line that is already at its active level at reset release from
    // looking like a fresh transition.
    logic [STAGES:0]   primed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain  <= {STAGES{RESET_VAL}};
            hist   <= RESET_VAL;
            primed <= '0;
        end else begin
            chain  <= {chain[STAGES-2:0], din};
            hist   <= chain[STAGES-1];
            primed <= {primed[STAGES-1:0], 1'b1};
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = primed[STAGES] &  sync & ~hist;
    assign fall = primed[STAGES] & ~sync &  hist;

endmodule

// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// SPI mode-0 responder, MSB first, oversampling sclk/cs/mosi on clk.
// Latency: rx_valid one clk after the synchronised last sclk rise; miso one clk after sync edge.
// Backpressure: one-entry tx buffer via tx_valid/tx_ready; rx has no backpressure (strobe).
//
// Ports:
//   clk, rst_n          : system clock (>= 8x sclk), asynchronous active-low reset
//   sclk, cs, mosi      : SPI bus from the master (cs active low)
//   miso, miso_oe       : serial data to master and its drive enable
//   tx_data/valid/ready : transmit word handshake into the one-entry buffer
//   rx_data, rx_valid   : last received word and its one-cycle strobe
//   busy                : synchronised cs inverted
//   frame_words         : words received in the current/last frame
//                         (only when SPI_SLAVE_WORD_CNT_EN is defined)
//
// Optional build macro: SPI_SLAVE_WORD_CNT_EN adds the frame_words output.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                 DATA_W      = SPI_DATA_W,
    parameter logic [DATA_W-1:0]  DEFAULT_TX  = DATA_W'(8'hFF),
    parameter int                 SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
`ifdef SPI_SLAVE_WORD_CNT_EN
    output logic [7:0]        frame_words,
`endif
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // ------------------------------------------------------------------
    // Synchronisers. mosi uses the same depth as sclk so the sampled data
    // bit lines up with the detected sclk rising edge.
    // ------------------------------------------------------------------
    logic sclk_level_unused;
    logic sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_sync;

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sclk),
        .sync  (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // cs resets to the deselected level so busy reads 0 out of reset.
    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cs),
        .sync  (cs_sync),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_sync = mosi_chain[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    spi_slave_state_t  state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] tx_buf;
    logic              tx_full;

    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] rx_next;
    logic              word_start;
    logic              tx_accept;

    // A word starts on cs falling edge, or on the sclk falling edge that
    // follows the last bit of a word while cs stays low. A cs rise in the
    // same cycle overrides any sclk edge.
    assign word_start = ((state == IDLE)   && cs_fall) ||
                        ((state == ACTIVE) && !cs_rise && sclk_fall && (bit_cnt == '0));

    // The load uses the buffer contents from before this cycle: a word
    // accepted in the same cycle stays queued for the following word.
    assign load_word = tx_full ? tx_buf : DEFAULT_TX;
    assign tx_accept = tx_valid && !tx_full;
    assign rx_next   = {rx_shift[DATA_W-2:0], mosi_sync};

    // Transmit buffer: accept and consume are mutually exclusive because
    // accept needs it empty and consume needs it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf  <= '0;
            tx_full <= 1'b0;
        end else if (word_start && tx_full) begin
            tx_full <= 1'b0;
        end else if (tx_accept) begin
            tx_buf  <= tx_data;
            tx_full <= 1'b1;
        end
    end

    assign tx_ready = !tx_full;
    assign busy     = !cs_sync;

    // ------------------------------------------------------------------
    // Bus FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
`ifdef SPI_SLAVE_WORD_CNT_EN
            frame_words <= 8'd0;
`endif
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= ACTIVE;
                        bit_cnt  <= '0;
                        tx_shift <= load_word;
                        miso     <= load_word[DATA_W-1];
                        miso_oe  <= 1'b1;
`ifdef SPI_SLAVE_WORD_CNT_EN
                        frame_words <= 8'd0;
`endif
                    end
                end

                ACTIVE: begin
                    if (cs_rise) begin
                        // Partial rx word and the loaded tx word are dropped.
                        state   <= IDLE;
                        bit_cnt <= '0;
                        miso    <= 1'b0;
                        miso_oe <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= rx_next;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt  <= '0;
                                rx_data  <= rx_next;
                                rx_valid <= 1'b1;
`ifdef SPI_SLAVE_WORD_CNT_EN
                                frame_words <= sat_inc8(frame_words);
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        if (sclk_fall) begin
                            if (bit_cnt != '0) begin
                                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                                miso     <= tx_shift[DATA_W-2];
                            end else begin
                                // Word boundary inside a multi-word frame.
                                tx_shift <= load_word;
                                miso     <= load_word[DATA_W-1];
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
